// File: rtl/uart_rx_fsm_ctrl.sv
// UART receiver sequencing controller: frame detection, edge/bit counters,
// and the enable/strobe decode for the sampler, checkers and deserializer.
module uart_rx_fsm_ctrl #(
  parameter int COUNTER_WIDTH  = 4,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [COUNTER_WIDTH-1:0]  bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      err_clr,
  output logic                      deser_en,
  output logic                      data_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0]  BIT_ZERO  = {COUNTER_WIDTH{1'b0}};

  state_e                    state_r, state_s;
  logic [PRESCALE_WIDTH-1:0] edge_r, edge_s;
  logic [PRESCALE_WIDTH-1:0] prescale_r, prescale_s;
  logic [PRESCALE_WIDTH-1:0] last_edge_s, half_edge_s;
  logic [COUNTER_WIDTH-1:0]  bit_r, bit_s;
  logic                      par_en_r, par_en_s;
  logic                      data_valid_r, data_valid_s;
  logic                      bit_end_s;

  // Frame parameters are latched at start detect, so both edges derive from the latched copy.
  assign last_edge_s = prescale_r - PRESCALE_WIDTH'(1);
  assign half_edge_s = (prescale_r >> 1) + PRESCALE_WIDTH'(2);
  assign bit_end_s   = (edge_r == last_edge_s);

  // State, counter and latched-parameter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      edge_r       <= EDGE_ZERO;
      bit_r        <= BIT_ZERO;
      prescale_r   <= EDGE_ZERO;
      par_en_r     <= 1'b0;
      data_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      edge_r       <= edge_s;
      bit_r        <= bit_s;
      prescale_r   <= prescale_s;
      par_en_r     <= par_en_s;
      data_valid_r <= data_valid_s;
    end
  end

  // Next-state, counter advance and frame-accept decision.
  always_comb begin
    state_s      = state_r;
    edge_s       = edge_r;
    bit_s        = bit_r;
    prescale_s   = prescale_r;
    par_en_s     = par_en_r;
    data_valid_s = 1'b0;

    if (state_r != IDLE) begin
      if (bit_end_s) begin
        edge_s = EDGE_ZERO;
        bit_s  = bit_r + COUNTER_WIDTH'(1);
      end else begin
        edge_s = edge_r + PRESCALE_WIDTH'(1);
      end
    end else begin
      edge_s = EDGE_ZERO;
      bit_s  = BIT_ZERO;
    end

    case (state_r)
      IDLE: begin
        // The detect cycle itself is edge 0 of the start bit.
        if (!RX_IN) begin
          state_s    = START;
          edge_s     = PRESCALE_WIDTH'(1);
          prescale_s = Prescale;
          par_en_s   = PAR_EN;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s && strt_glitch) begin
          state_s = IDLE;
          edge_s  = EDGE_ZERO;
          bit_s   = BIT_ZERO;
        end else if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_r == COUNTER_WIDTH'(8))) begin
          state_s = par_en_r ? PARITY : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_s      = IDLE;
          edge_s       = EDGE_ZERO;
          bit_s        = BIT_ZERO;
          data_valid_s = !stp_err && !(par_en_r && par_err);
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        edge_s  = EDGE_ZERO;
        bit_s   = BIT_ZERO;
      end
    endcase
  end

  assign edge_cnt    = edge_r;
  assign bit_cnt     = bit_r;
  assign dat_samp_en = (state_r != IDLE);
  assign strt_chk_en = (state_r == START)  && (edge_r == half_edge_s);
  assign deser_en    = (state_r == DATA)   && (edge_r == half_edge_s);
  assign par_chk_en  = (state_r == PARITY) && (edge_r == half_edge_s);
  assign err_clr     = (state_r == START)  && (edge_r == PRESCALE_WIDTH'(1)) && (bit_r == BIT_ZERO);
  assign data_valid  = data_valid_r;

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// Self-checking bench for uart_rx_fsm_ctrl: directed frames plus random frames
// compared cycle by cycle against a frame-timing model.
module tb_uart_rx_fsm_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, err_clr, deser_en, data_valid;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int deser_seen = 0;

  // model: busy flag, cycles since start detect, latched P/parity, pending data_valid
  logic m_busy = 1'b0;
  int   m_t    = 0;
  int   m_p    = 8;
  logic m_par  = 1'b0;
  logic m_dv   = 1'b0;

  uart_rx_fsm_ctrl #(.COUNTER_WIDTH(4), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .err_clr(err_clr),
    .deser_en(deser_en), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] rand_pre();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  task automatic chk_all_zero();
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_outputs", 32'({dat_samp_en, strt_chk_en, par_chk_en, err_clr, deser_en, data_valid}), 32'd0);
  endtask

  // One clock cycle: check outputs of the current cycle, apply its inputs, advance the model.
  task automatic step(input logic rx, input logic [5:0] pre, input logic pen,
                      input logic gl, input logic pe, input logic se);
    int e_edge, e_bit, h, n;
    logic e_samp, e_strt, e_deser, e_par, e_clr;
    @(negedge CLK);
    e_edge = 0; e_bit = 0; e_samp = 1'b0; e_strt = 1'b0; e_deser = 1'b0; e_par = 1'b0; e_clr = 1'b0;
    if (m_busy) begin
      e_edge  = m_t % m_p;
      e_bit   = m_t / m_p;
      h       = m_p / 2 + 2;
      e_samp  = 1'b1;
      e_strt  = (e_bit == 0) && (e_edge == h);
      e_deser = (e_bit >= 1) && (e_bit <= 8) && (e_edge == h);
      e_par   = m_par && (e_bit == 9) && (e_edge == h);
      e_clr   = (m_t == 1);
    end
    chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
    chk("bit_cnt", 32'(bit_cnt), 32'(e_bit));
    chk("dat_samp_en", 32'(dat_samp_en), 32'(e_samp));
    chk("strt_chk_en", 32'(strt_chk_en), 32'(e_strt));
    chk("deser_en", 32'(deser_en), 32'(e_deser));
    chk("par_chk_en", 32'(par_chk_en), 32'(e_par));
    chk("err_clr", 32'(err_clr), 32'(e_clr));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    if (deser_en === 1'b1) deser_seen++;
    RX_IN = rx; Prescale = pre; PAR_EN = pen; strt_glitch = gl; par_err = pe; stp_err = se;
    m_dv = 1'b0;
    if (!RST) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (!rx) begin
        m_busy = 1'b1; m_t = 1; m_p = int'(pre); m_par = pen;
      end
    end else begin
      n = (m_par ? 11 : 10) * m_p;
      if (m_t == m_p - 1 && gl) begin
        m_busy = 1'b0;
      end else if (m_t == n - 1) begin
        m_busy = 1'b0;
        m_dv   = !se && !(m_par && pe);
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b1, rand_pre(), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Start detect plus the whole frame (or up to the glitch decision); inputs mid-frame are scrambled.
  task automatic run_frame(input int p, input logic par, input logic gl, input logic pe, input logic se);
    int n, last;
    logic g, e1, e2;
    n    = (par ? 11 : 10) * p;
    last = gl ? p - 1 : n - 1;
    deser_seen = 0;
    step(1'b0, 6'(p), par, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int t = 1; t <= last; t++) begin
      g  = (t == p - 1) ? gl : 1'($urandom);
      e1 = (t == last) ? pe : 1'($urandom);
      e2 = (t == last) ? se : 1'($urandom);
      step(1'($urandom), rand_pre(), 1'($urandom), g, e1, e2);
    end
    if (!gl) chk("deser_pulses", 32'(deser_seen), 32'd8);
    else chk("glitch_no_deser", 32'(deser_seen), 32'd0);
  endtask

  initial begin
    #1;
    chk_all_zero();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    idle(3);

    // P=8 clean frame, then start glitch, then parity frame with par_err
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    run_frame(8, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // stop error frame followed back-to-back by two clean frames
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    run_frame(32, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // asynchronous reset in data bit 4
    step(1'b0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t < 4 * 8 + 3; t++) step(1'($urandom), 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 RST = 1'b0;
    m_busy = 1'b0; m_dv = 1'b0;
    #1 chk_all_zero();
    idle(3);
    RST = 1'b1;
    idle(5);

    // randomized frames with random gaps, glitches and errors
    for (int f = 0; f < 16; f++) begin
      run_frame(int'(rand_pre()), 1'($urandom), ($urandom_range(0, 4) == 0),
                1'($urandom), ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm_ctrl.md
# uart_rx_fsm_ctrl

Sequencing controller for the UART receiver. It detects the start of a frame on the oversampled serial line and maintains the per-bit edge counter and the per-frame bit counter. It drives the enables and clears for the data sampler, start/parity/stop checkers and deserializer, and raises a one-cycle `data_valid` when a frame completes without error. It sits in UART_RX between the synchronized RX line and the per-bit checker/datapath modules.

## Interface
- `COUNTER_WIDTH`, default 4: width of `bit_cnt`.
- `PRESCALE_WIDTH`, default 6: width of `Prescale` and `edge_cnt`.

- `CLK`  in  1  UART RX oversampling clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `RX_IN`  in  1  synchronized serial line, idle high.
- `PAR_EN`  in  1  parity bit present in frame.
- `Prescale`  in  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- `strt_glitch`  in  1  start checker result; 1 means the start bit was sampled high.
- `par_err`  in  1  parity checker error flag.
- `stp_err`  in  1  stop checker error flag.
- `edge_cnt`  out  PRESCALE_WIDTH  oversampling edge index within the current bit.
- `bit_cnt`  out  COUNTER_WIDTH  bit index within the frame.
  - 0 = start bit.
  - 1..8 = data bits, LSB first.
  - 9 = parity bit when `PAR_EN`=1, otherwise stop bit.
  - 10 = stop bit when `PAR_EN`=1.
- `dat_samp_en`  out  1  data sampler enable.
- `strt_chk_en`  out  1  start checker evaluate strobe.
- `par_chk_en`  out  1  parity checker evaluate strobe.
- `err_clr`  out  1  clears the parity and stop error flags for the new frame.
- `deser_en`  out  1  deserializer shift strobe.
- `data_valid`  out  1  frame accepted pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- Latching: `Prescale` and `PAR_EN` are latched into internal registers on the IDLE->START transition. They are used unchanged for the whole frame; mid-frame input changes are ignored.
- Let P = latched Prescale, H = P/2 + 2 (the edge at which the sampler result is valid), L = P-1 (last edge of a bit).
- IDLE:
  - `edge_cnt`=0, `bit_cnt`=0.
  - If `RX_IN`=0, this cycle is edge 0 of bit 0: next state is START with `edge_cnt`=1.
- Counters, in any non-IDLE state:
  - `edge_cnt` increments every cycle.
  - At edge L, `edge_cnt` wraps to 0 and `bit_cnt` increments.
- START, decision at edge L:
  - `strt_glitch`=1 -> IDLE, counters cleared to 0.
  - Otherwise -> DATA.
- DATA: at edge L with `bit_cnt`=8 -> PARITY if latched `PAR_EN`, else STOP.
- PARITY: at edge L -> STOP.
- STOP, decision at edge L:
  - Next state is IDLE, counters cleared to 0.
  - `data_valid` asserts next cycle iff `par_err`=0 and `stp_err`=0 in the decision cycle. `par_err` is treated as 0 when parity is disabled.
- `dat_samp_en`: 1 in every non-IDLE state, 0 in IDLE.
- Strobes, all asserted for exactly 1 cycle at edge H:
  - `strt_chk_en` in START.
  - `deser_en` in DATA, giving 8 pulses per frame.
  - `par_chk_en` in PARITY.
- `err_clr`: 1 for exactly the first START cycle (`edge_cnt`=1, `bit_cnt`=0).
- Widths: `edge_cnt` compare against P-1 uses the full PRESCALE_WIDTH; P=32 fits in 6 bits. `bit_cnt` never exceeds 10.

## Timing
- All outputs are registered or decoded from registered state and counters only. There are no combinational paths from inputs to outputs.
- Reset values, applied asynchronously and immediately: state IDLE, all outputs 0.
- Reset asserted mid-frame aborts the frame: no `data_valid`, all strobes 0. After release the block waits in IDLE for `RX_IN`=0.
- Take the start-detect cycle as cycle 0. With no parity:
  - Stop decision at cycle 10P-1.
  - `data_valid` high in cycle 10P, for 1 cycle.
  - The block is in IDLE in cycle 10P.
- With parity, each of those figures becomes 11P.
- Back-to-back frames: if `RX_IN`=0 in cycle 10P, that cycle is the next frame's edge 0. `data_valid` for the finished frame still asserts in that cycle.
- Glitch abort: IDLE at cycle P. A new start may be detected from cycle P onward.
- Illegal Prescale values (not 8, 16 or 32) give unspecified behaviour and are not verified.

## Test plan
- P=8, PAR_EN=0, frame 0xA5, stop=1 -> `deser_en` pulses at cycles 8k+6 for k=1..8; `data_valid`=1 only at cycle 80; IDLE at cycle 80.
- RX_IN low for 2 cycles, `strt_glitch`=1 at cycle 7 -> `strt_chk_en` at cycle 6 only; IDLE at cycle 8; no `deser_en`, no `data_valid`.
- P=16, PAR_EN=1, `par_err`=1 at the stop decision -> `par_chk_en` at cycle 154; no `data_valid`; IDLE at cycle 176.
- P=8, PAR_EN=0, `stp_err`=1 at cycle 79 -> no `data_valid`; `err_clr` at cycle 1 of the next frame.
- Two back-to-back frames, P=8, second start at cycle 80 -> `data_valid` at cycles 80 and 160; second frame `edge_cnt`=1 at cycle 81.
- RST low during DATA bit 4 -> all outputs 0 in the same cycle; after release with RX_IN=1 the block stays in IDLE.
